pulse_cmd_sched: RTL and testbench
==================================

Name: pulse_cmd_sched

Overview:
- Command controller between `uart_rx` and the dual-pulse generator (`functionGenerate`).
- Collects 8-byte UART frames in the `sys_clk` domain, using `po_flag` as a data-valid strobe, never as a clock.
- Validates each frame with a header, command code and XOR checksum, latches the pulse configuration, and schedules single or burst fire strobes.
- Returns one status byte per frame through `uart_tx`.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 9600, baud rate; sets the inter-byte timeout.
- TIMEOUT_BYTES, 3, idle time in byte-times after which a partial frame is discarded.
- PERIOD_UNIT, 50, clock cycles per burst-period LSB (1 µs at 50 MHz).

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from `uart_rx` (`po_data`).
- rx_flag  in  1  one-cycle valid for rx_data (`po_flag`).
- pulse_width1  out  7  width of first pulse, in clock units.
- pulse_width2  out  7  width of second pulse, in clock units.
- pulse_gap  out  7  gap between the two pulses, in clock units.
- fire  out  1  one-cycle fire strobe to the generator (`uart_flag`).
- busy  out  1  high while a burst is active.
- tx_data  out  8  status byte to `uart_tx` (`pi_data`).
- tx_flag  out  1  one-cycle send strobe (`pi_flag`).

Behaviour:
- Reset (async, active-low): all outputs 0; byte counter 0; scheduler in S_IDLE; burst counter 0. Reset mid-burst aborts immediately.
- Frame layout, bytes B0..B7:
  - B0 = 0x07 (header).
  - B1 = cmd.
  - B2 = w1, B3 = w2, B4 = gap; only bits [6:0] are used.
  - B5 = burst count N, 0 treated as 1.
  - B6 = period P in PERIOD_UNIT cycles, 0 treated as 1.
  - B7 = XOR of B0..B6.
- Byte collection:
  - Each rx_flag stores rx_data at index cnt, then cnt increments.
  - If cnt==0 and the byte is not 0x07, the byte is dropped and cnt stays 0 (resynchronisation).
  - Timeout counter clears on rx_flag and counts while cnt!=0. At TIMEOUT_BYTES*10*CLK_FREQ/UART_BPS cycles, cnt goes to 0 and no ack is sent.
- Frame complete: the cycle after B7 is stored, evaluate in this priority order:
  1. Checksum mismatch -> ack 0xE1.
  2. cmd not in {0x01, 0x02, 0x03, 0x04} -> ack 0xE2.
  3. busy and cmd!=0x04 -> ack 0xE3; config unchanged.
  4. Otherwise -> ack 0xA5 and execute.
- Commands:
  - 0x01 single fire: latch w1/w2/gap, start a burst with N=1.
  - 0x02 config only: latch w1/w2/gap, no fire.
  - 0x03 burst: latch w1/w2/gap/N/P, start burst.
  - 0x04 abort: go to S_IDLE, busy=0; acked 0xA5 even when idle.
- Ack timing: tx_flag pulses exactly 1 cycle, 1 cycle after frame complete, with tx_data stable from that cycle until the next ack. Exactly one ack per complete frame. Frame duration exceeds one tx byte-time, so no tx queue is needed.
- Scheduler states:
  - S_IDLE: wait for start -> S_FIRE.
  - S_FIRE: fire=1 for one cycle; load wait counter with P*PERIOD_UNIT-1; decrement remaining count -> S_WAIT.
  - S_WAIT: count down. At 0: remaining>0 -> S_FIRE, else -> S_IDLE.
- Burst timing:
  - First fire occurs 2 cycles after frame complete.
  - Consecutive fires are exactly P*PERIOD_UNIT cycles apart (16-bit wait counter, max 255*PERIOD_UNIT).
  - busy=1 from S_FIRE entry until return to S_IDLE.
- Config outputs change only on accepted 0x01/0x02/0x03 commands. They are never modified while busy, so the generator sees stable widths during a burst.
- Bytes received while busy are still collected; only execution is gated.
- Simultaneous events: an abort evaluated in the same cycle as a scheduled fire wins, and no fire is issued.

Decomposition:
- Shared package `pulse_cmd_pkg`:
  - Constants HDR=0x07, CMD_FIRE/CMD_CFG/CMD_BURST/CMD_ABORT, ACK_OK=0xA5, ERR_CSUM=0xE1, ERR_CMD=0xE2, ERR_BUSY=0xE3.
  - Scheduler state enumeration.
- One sub-module `pulse_frame_rx`: byte collection, resync, timeout and checksum.
  - Outputs frame_done plus frame_ok/bytes.
  - The top holds command decode, config registers, scheduler and ack.

Test Plan:
- Send 07 01 10 20 08 00 00 XX (valid checksum) -> widths 0x10/0x20/0x08; one fire 2 cycles after frame; tx 0xA5.
- Send 07 03 05 05 02 03 0A XX -> 3 fires spaced 500 cycles; busy high from first fire through 500 cycles after last; tx 0xA5.
- Mid-burst, send a 0x02 frame -> tx 0xE3, widths unchanged. Then send a 0x04 frame -> tx 0xA5, no further fires, busy=0.
- Send a frame with a bad checksum -> tx 0xE1, outputs unchanged. Send cmd 0x09 -> tx 0xE2.
- Send junk 0x55 0xAA, then a valid frame -> junk dropped, frame accepted. Send 4 bytes and stall past the timeout, then a full valid frame -> only one ack (0xA5).
- Assert sys_rst_n low during S_WAIT -> all outputs 0 immediately; no fire after release.

Source files
------------

// File: rtl/pulse_cmd_pkg.sv
// rtl/pulse_cmd_pkg.sv - shared constants, frame type and scheduler states for pulse_cmd_sched
package pulse_cmd_pkg;

    localparam logic [7:0] HDR       = 8'h07;
    localparam logic [7:0] CMD_FIRE  = 8'h01;
    localparam logic [7:0] CMD_CFG   = 8'h02;
    localparam logic [7:0] CMD_BURST = 8'h03;
    localparam logic [7:0] CMD_ABORT = 8'h04;
    localparam logic [7:0] ACK_OK    = 8'hA5;
    localparam logic [7:0] ERR_CSUM  = 8'hE1;
    localparam logic [7:0] ERR_CMD   = 8'hE2;
    localparam logic [7:0] ERR_BUSY  = 8'hE3;

    // Eight received bytes, index 0 is the header byte
    typedef logic [7:0][7:0] frame_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2
    } sched_state_t;

    // XOR of bytes 0..6, compared against byte 7
    function automatic logic [7:0] frame_csum(input frame_t f);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 7; i++) begin
            x = x ^ f[i];
        end
        return x;
    endfunction

endpackage

// File: rtl/pulse_cmd_sched_if.sv
// rtl/pulse_cmd_sched_if.sv - uart byte, pulse config, fire and status signals of pulse_cmd_sched
interface pulse_cmd_sched_if;

    logic [7:0] rx_data;
    logic       rx_flag;
    logic [6:0] pulse_width1;
    logic [6:0] pulse_width2;
    logic [6:0] pulse_gap;
    logic       fire;
    logic       busy;
    logic [7:0] tx_data;
    logic       tx_flag;

    // Scheduler side: consumes uart bytes, drives pulse config, fire and status
    modport master (
        input  rx_data,
        input  rx_flag,
        output pulse_width1,
        output pulse_width2,
        output pulse_gap,
        output fire,
        output busy,
        output tx_data,
        output tx_flag
    );

    // Environment side: uart_rx, pulse generator and uart_tx
    modport slave (
        output rx_data,
        output rx_flag,
        input  pulse_width1,
        input  pulse_width2,
        input  pulse_gap,
        input  fire,
        input  busy,
        input  tx_data,
        input  tx_flag
    );

endinterface

// File: rtl/pulse_frame_rx.sv
// rtl/pulse_frame_rx.sv - 8-byte frame collector with header resync, inter-byte timeout and checksum
module pulse_frame_rx
    import pulse_cmd_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int UART_BPS      = 9600,
    parameter int TIMEOUT_BYTES = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_flag,
    output logic       frame_done,
    output logic       frame_ok,
    output frame_t     frame_bytes
);

    localparam longint unsigned TMO_CYC =
        (longint'(TIMEOUT_BYTES) * 64'd10 * longint'(CLK_FREQ)) / longint'(UART_BPS);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [2:0]       cnt_q;
    logic [TMO_W-1:0] tmo_q;
    frame_t           bytes_q;
    logic             done_q;

    // Store bytes at the current index; a non-header byte at index 0 is dropped so
    // the collector realigns on the next 0x07, and a stalled partial frame is discarded
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q   <= '0;
            tmo_q   <= '0;
            bytes_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rx_flag) begin
                tmo_q <= '0;
                if (cnt_q != 3'd0 || rx_data == HDR) begin
                    bytes_q[cnt_q] <= rx_data;
                    cnt_q          <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        done_q <= 1'b1;
                    end
                end
            end else if (cnt_q != 3'd0) begin
                if (tmo_q == TMO_LAST) begin
                    cnt_q <= '0;
                    tmo_q <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    assign frame_done  = done_q;
    assign frame_bytes = bytes_q;
    assign frame_ok    = (frame_csum(bytes_q) == bytes_q[7]);

endmodule

// File: rtl/pulse_cmd_sched.sv
// rtl/pulse_cmd_sched.sv - frame decode, pulse config registers, fire scheduler and status ack
module pulse_cmd_sched
    import pulse_cmd_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int UART_BPS      = 9600,
    parameter int TIMEOUT_BYTES = 3,
    parameter int PERIOD_UNIT   = 50
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    pulse_cmd_sched_if.master bus
);

    logic         frame_done;
    logic         frame_ok;
    frame_t       fb;
    logic [7:0]   cmd;
    logic         cmd_known;
    logic         sched_busy;
    logic [7:0]   ack_code;
    logic         exec;
    logic         abort_now;
    logic         load_burst;
    logic [7:0]   burst_n;
    logic [7:0]   period_eff;
    logic [15:0]  period_cyc;

    sched_state_t state_q, state_d;
    logic         fire_d;
    logic         start_q;
    logic [15:0]  wait_q;
    logic [7:0]   rem_q;
    logic [7:0]   period_q;
    logic [6:0]   w1_q, w2_q, gap_q;
    logic [7:0]   tx_data_q;
    logic         tx_flag_q;
    logic         unused_bits;

    pulse_frame_rx #(
        .CLK_FREQ      (CLK_FREQ),
        .UART_BPS      (UART_BPS),
        .TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) u_frame_rx (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .rx_data     (bus.rx_data),
        .rx_flag     (bus.rx_flag),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .frame_bytes (fb)
    );

    assign cmd        = fb[1];
    assign cmd_known  = (cmd == CMD_FIRE) || (cmd == CMD_CFG) ||
                        (cmd == CMD_BURST) || (cmd == CMD_ABORT);
    assign sched_busy = (state_q != S_IDLE);
    assign burst_n    = (fb[5] == 8'd0) ? 8'd1 : fb[5];
    assign period_eff = (period_q == 8'd0) ? 8'd1 : period_q;
    assign period_cyc = 16'(period_eff) * 16'(PERIOD_UNIT);

    // Header, checksum byte and width MSBs carry no information past the collector
    assign unused_bits = ^{fb[0], fb[7], fb[2][7], fb[3][7], fb[4][7]};

    // Pick the status byte by priority; only a fully accepted frame executes
    always_comb begin
        ack_code = ACK_OK;
        exec     = 1'b0;
        if (!frame_ok) begin
            ack_code = ERR_CSUM;
        end else if (!cmd_known) begin
            ack_code = ERR_CMD;
        end else if (sched_busy && cmd != CMD_ABORT) begin
            ack_code = ERR_BUSY;
        end else begin
            exec = 1'b1;
        end
    end

    assign abort_now  = frame_done && exec && (cmd == CMD_ABORT);
    assign load_burst = frame_done && exec && (cmd == CMD_FIRE || cmd == CMD_BURST);

    // Ack every completed frame and latch config; exec is only set when idle for 01/02/03,
    // so widths stay frozen for the whole burst
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_flag_q <= 1'b0;
            tx_data_q <= '0;
            start_q   <= 1'b0;
            w1_q      <= '0;
            w2_q      <= '0;
            gap_q     <= '0;
            period_q  <= '0;
        end else begin
            tx_flag_q <= 1'b0;
            start_q   <= 1'b0;
            if (frame_done) begin
                tx_flag_q <= 1'b1;
                tx_data_q <= ack_code;
                if (exec && cmd != CMD_ABORT) begin
                    w1_q  <= fb[2][6:0];
                    w2_q  <= fb[3][6:0];
                    gap_q <= fb[4][6:0];
                end
                if (exec && cmd == CMD_BURST) begin
                    period_q <= fb[6];
                end
                start_q <= load_burst;
            end
        end
    end

    // Scheduler state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scheduler next state; the S_FIRE cycle counts toward the period, so S_WAIT leaves
    // when the counter reaches 1. An abort overrides everything, including a fire due now
    always_comb begin
        state_d = state_q;
        fire_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                fire_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q < 16'd2) begin
                    state_d = (rem_q != 8'd0) ? S_FIRE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_now) begin
            state_d = S_IDLE;
            fire_d  = 1'b0;
        end
    end

    // Remaining-fire and period countdown registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_q <= '0;
            rem_q  <= '0;
        end else if (load_burst) begin
            rem_q <= (cmd == CMD_FIRE) ? 8'd1 : burst_n;
        end else if (state_q == S_FIRE) begin
            wait_q <= period_cyc - 16'd1;
            rem_q  <= rem_q - 8'd1;
        end else if (state_q == S_WAIT && wait_q != 16'd0) begin
            wait_q <= wait_q - 16'd1;
        end
    end

    assign bus.pulse_width1 = w1_q;
    assign bus.pulse_width2 = w2_q;
    assign bus.pulse_gap    = gap_q;
    assign bus.fire         = fire_d;
    assign bus.busy         = sched_busy;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_flag      = tx_flag_q;

endmodule

// File: tb/tb_pulse_cmd_sched.sv
// tb/tb_pulse_cmd_sched.sv - self-checking bench for pulse_cmd_sched with a frame-level reference model
module tb_pulse_cmd_sched;

    localparam int TMO  = 3 * 10 * 50_000_000 / 9600;
    localparam int UNIT = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    pulse_cmd_sched_if bus();

    pulse_cmd_sched #(
        .CLK_FREQ      (50_000_000),
        .UART_BPS      (9600),
        .TIMEOUT_BYTES (3),
        .PERIOD_UNIT   (UNIT)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed activity, cycle-stamped
    int         fire_log[$];
    int         tx_cyc_log[$];
    logic [7:0] tx_dat_log[$];
    int         busy_cyc_log[$];
    logic       busy_val_log[$];
    logic       busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fire) fire_log.push_back(cyc);
            if (bus.tx_flag) begin
                tx_cyc_log.push_back(cyc);
                tx_dat_log.push_back(bus.tx_data);
            end
            if (bus.busy !== busy_prev) begin
                busy_cyc_log.push_back(cyc);
                busy_val_log.push_back(bus.busy);
                busy_prev = bus.busy;
            end
        end
    end

    // Reference model state
    logic [7:0] mbuf[$];
    int         last_c = -1000000;
    int         exp_fire[$];
    int         exp_ack_c[$];
    logic [7:0] exp_ack_d[$];
    int         blo[$];
    int         bhi[$];
    logic [6:0] m_w1 = '0, m_w2 = '0, m_gap = '0;
    logic [7:0] m_p = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input logic [7:0] v);
        return (v == 8'd0) ? 1 : int'(v);
    endfunction

    // Frame completes at cycle f: ack at f+1, fires at f+2 + j*P*UNIT
    task automatic model_frame(input int f);
        logic [7:0] x;
        logic [7:0] c;
        logic       bz;
        int         n;
        int         k;
        x = '0;
        for (int i = 0; i < 7; i++) x = x ^ mbuf[i];
        c  = mbuf[1];
        bz = (bhi.size() > 0) && (f < bhi[bhi.size()-1]);
        exp_ack_c.push_back(f + 1);
        if (x != mbuf[7]) begin
            exp_ack_d.push_back(8'hE1);
        end else if (c < 8'd1 || c > 8'd4) begin
            exp_ack_d.push_back(8'hE2);
        end else if (bz && c != 8'd4) begin
            exp_ack_d.push_back(8'hE3);
        end else begin
            exp_ack_d.push_back(8'hA5);
            if (c == 8'd4) begin
                while (exp_fire.size() > 0 && exp_fire[$] >= f) void'(exp_fire.pop_back());
                if (bz) bhi[bhi.size()-1] = f + 1;
            end else begin
                m_w1  = mbuf[2][6:0];
                m_w2  = mbuf[3][6:0];
                m_gap = mbuf[4][6:0];
                n = 1;
                if (c == 8'd3) begin
                    n   = eff(mbuf[5]);
                    m_p = mbuf[6];
                end
                if (c != 8'd2) begin
                    k = eff(m_p) * UNIT;
                    for (int j = 0; j < n; j++) exp_fire.push_back(f + 2 + j * k);
                    blo.push_back(f + 2);
                    bhi.push_back(f + 2 + n * k);
                end
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int c);
        if (mbuf.size() > 0 && (c - last_c - 1) >= TMO) mbuf.delete();
        last_c = c;
        if (mbuf.size() == 0 && b != 8'h07) return;
        mbuf.push_back(b);
        if (mbuf.size() == 8) begin
            model_frame(c + 1);
            mbuf.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        bus.rx_data = b;
        bus.rx_flag = 1'b1;
        model_byte(b, cyc);
        @(posedge clk);
        #1;
        bus.rx_flag = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] w1, input logic [7:0] w2,
                              input logic [7:0] gp, input logic [7:0] n, input logic [7:0] p,
                              input bit bad, input int bgap);
        logic [7:0] fr[8];
        fr[0] = 8'h07; fr[1] = c; fr[2] = w1; fr[3] = w2;
        fr[4] = gp;    fr[5] = n; fr[6] = p;
        fr[7] = 8'h00;
        for (int i = 0; i < 7; i++) fr[7] = fr[7] ^ fr[i];
        if (bad) fr[7] = fr[7] ^ 8'h5A;
        for (int i = 0; i < 8; i++) send_byte(fr[i], bgap);
        repeat (3) @(posedge clk);
        #1;
        chk("pulse_width1", 32'(bus.pulse_width1), 32'(m_w1));
        chk("pulse_width2", 32'(bus.pulse_width2), 32'(m_w2));
        chk("pulse_gap",    32'(bus.pulse_gap),    32'(m_gap));
    endtask

    task automatic compare_logs();
        int m;
        chk("fire_count", fire_log.size(), exp_fire.size());
        m = (fire_log.size() < exp_fire.size()) ? fire_log.size() : exp_fire.size();
        for (int i = 0; i < m; i++) chk($sformatf("fire_cycle[%0d]", i), fire_log[i], exp_fire[i]);
        chk("ack_count", tx_cyc_log.size(), exp_ack_c.size());
        m = (tx_cyc_log.size() < exp_ack_c.size()) ? tx_cyc_log.size() : exp_ack_c.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("ack_cycle[%0d]", i), tx_cyc_log[i], exp_ack_c[i]);
            chk($sformatf("ack_data[%0d]", i), 32'(tx_dat_log[i]), 32'(exp_ack_d[i]));
        end
        chk("busy_edges", busy_cyc_log.size(), 2 * blo.size());
        m = (busy_cyc_log.size() < 2 * blo.size()) ? busy_cyc_log.size() : 2 * blo.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("busy_edge_cycle[%0d]", i), busy_cyc_log[i],
                (i % 2 == 0) ? blo[i/2] : bhi[i/2]);
            chk($sformatf("busy_edge_val[%0d]", i), 32'(busy_val_log[i]), 32'((i % 2) == 0));
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_fire"},    32'(bus.fire),         32'd0);
        chk({pfx, "_busy"},    32'(bus.busy),         32'd0);
        chk({pfx, "_tx_flag"}, 32'(bus.tx_flag),      32'd0);
        chk({pfx, "_tx_data"}, 32'(bus.tx_data),      32'd0);
        chk({pfx, "_w1"},      32'(bus.pulse_width1), 32'd0);
        chk({pfx, "_w2"},      32'(bus.pulse_width2), 32'd0);
        chk({pfx, "_gap"},     32'(bus.pulse_gap),    32'd0);
    endtask

    initial begin
        logic [7:0] rc, rw1, rw2, rg, rn, rp;
        int         r;
        bit         rbad;

        bus.rx_data = '0;
        bus.rx_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single fire with default period
        send_frame(8'h01, 8'h10, 8'h20, 8'h08, 8'h00, 8'h00, 1'b0, 1);
        repeat (100) @(posedge clk);

        // Three-fire burst, 500-cycle spacing
        send_frame(8'h03, 8'h05, 8'h05, 8'h02, 8'h03, 8'h0A, 1'b0, 2);
        repeat (1600) @(posedge clk);

        // Burst again: config attempt while busy is refused, then abort
        send_frame(8'h03, 8'h05, 8'h05, 8'h02, 8'h03, 8'h0A, 1'b0, 1);
        repeat (50) @(posedge clk);
        send_frame(8'h02, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 1'b0, 1);
        repeat (500) @(posedge clk);
        send_frame(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        chk("busy_after_abort", 32'(bus.busy), 32'd0);
        repeat (1200) @(posedge clk);

        // Bad checksum, unknown command
        send_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 1'b1, 1);
        send_frame(8'h09, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 1'b0, 1);

        // Junk before a frame
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_frame(8'h02, 8'h44, 8'h45, 8'h46, 8'h00, 8'h00, 1'b0, 1);

        // Partial frame abandoned past the timeout
        send_byte(8'h07, 1);
        send_byte(8'h01, 1);
        send_byte(8'h10, 1);
        send_byte(8'h20, 1);
        repeat (TMO + 400) @(posedge clk);
        send_frame(8'h02, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 1'b0, 1);

        // Randomized frames, some landing inside bursts
        for (int it = 0; it < 14; it++) begin
            r    = $urandom_range(0, 9);
            rbad = 1'b0;
            rc   = 8'h01;
            if (r >= 3 && r <= 4) rc = 8'h02;
            if (r >= 5 && r <= 6) rc = 8'h03;
            if (r == 7) rc = 8'h04;
            if (r == 8) rc = 8'($urandom_range(5, 255));
            if (r == 9) begin rc = 8'h03; rbad = 1'b1; end
            rw1 = 8'($urandom);
            rw2 = 8'($urandom);
            rg  = 8'($urandom);
            rn  = 8'($urandom_range(0, 3));
            rp  = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(8, 255)), 1);
            send_frame(rc, rw1, rw2, rg, rn, rp, rbad, $urandom_range(0, 3));
            repeat ($urandom_range(0, 300)) @(posedge clk);
        end
        repeat (1000) @(posedge clk);
        compare_logs();

        // Reset during S_WAIT
        send_frame(8'h03, 8'h05, 8'h05, 8'h02, 8'h03, 8'h0A, 1'b0, 1);
        repeat (120) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midburst_reset");
        fire_log.delete();
        tx_cyc_log.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        chk("fires_after_reset", fire_log.size(), 0);
        chk("acks_after_reset", tx_cyc_log.size(), 0);
        chk("busy_after_reset", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
